// File: rtl/pio_pkg.sv
// Shared constants for the Avalon-MM PIO slave: register word addresses and
// edge-capture mode encodings.
package pio_pkg;

  localparam logic [2:0] PIO_DATA    = 3'd0;
  localparam logic [2:0] PIO_INPUT   = 3'd1;
  localparam logic [2:0] PIO_IRQMASK = 3'd2;
  localparam logic [2:0] PIO_EDGECAP = 3'd3;
  localparam logic [2:0] PIO_OUTSET  = 3'd4;
  localparam logic [2:0] PIO_OUTCLR  = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_edge_detect.sv
// Input path of the PIO: multi-stage synchroniser, one-cycle history flop and a
// priming counter that masks edge detection until the pipeline holds real data.
module pio_edge_detect
  import pio_pkg::*;
#(
  parameter int IN_WIDTH    = 4,
  parameter int EDGE_TYPE   = EDGE_RISE,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [IN_WIDTH-1:0] in_i,
  output logic [IN_WIDTH-1:0] sync_o,
  output logic [IN_WIDTH-1:0] edge_o
);

  localparam int PRIME_MAX = SYNC_STAGES + 1;
  localparam int CW        = $clog2(PRIME_MAX + 1);

  logic [IN_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [IN_WIDTH-1:0] prev_q;
  logic [CW-1:0]       prime_cnt_q;
  logic                primed;
  logic [IN_WIDTH-1:0] edge_raw;

  assign primed = (prime_cnt_q == CW'(PRIME_MAX));
  assign sync_o = sync_q[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbour and the chain shifts by one.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q      <= '0;
      prime_cnt_q <= '0;
    end else begin
      sync_q[0] <= in_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
      if (!primed) prime_cnt_q <= prime_cnt_q + CW'(1);
    end
  end

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    edge_raw = sync_o & ~prev_q;
    case (EDGE_TYPE)
      EDGE_FALL: edge_raw = ~sync_o & prev_q;
      EDGE_ANY:  edge_raw = sync_o ^ prev_q;
      default:   ;
    endcase
  end

  // Zeros in the reset state look like edges against a held-high input.
  assign edge_o = primed ? edge_raw : '0;

endmodule

// File: rtl/avalon_pio_irq.sv
// Avalon-MM PIO slave: output port with atomic set/clear, synchronised input
// port with per-bit edge capture, and a maskable level interrupt.
module avalon_pio_irq
  import pio_pkg::*;
#(
  parameter int                   OUT_WIDTH   = 10,
  parameter int                   IN_WIDTH    = 4,
  parameter logic [OUT_WIDTH-1:0] RESET_VALUE = '0,
  parameter int                   EDGE_TYPE   = EDGE_RISE,
  parameter int                   SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [2:0]           address,
  input  logic                 chipselect,
  input  logic                 write_n,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  input  logic [IN_WIDTH-1:0]  in_port,
  output logic [OUT_WIDTH-1:0] out_port,
  output logic                 irq
);

  logic [OUT_WIDTH-1:0] data_q, data_d;
  logic [IN_WIDTH-1:0]  mask_q, mask_d;
  logic [IN_WIDTH-1:0]  cap_q, cap_d;
  logic [IN_WIDTH-1:0]  w1c;
  logic [IN_WIDTH-1:0]  in_sync;
  logic [IN_WIDTH-1:0]  edge_pulse;
  logic                 wr;
  logic                 unused_wd;

  assign unused_wd = ^writedata;
  assign wr        = chipselect & ~write_n;

  pio_edge_detect #(
    .IN_WIDTH    (IN_WIDTH),
    .EDGE_TYPE   (EDGE_TYPE),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .in_i    (in_port),
    .sync_o  (in_sync),
    .edge_o  (edge_pulse)
  );

  always_comb begin
    data_d = data_q;
    mask_d = mask_q;
    w1c    = '0;
    if (wr) begin
      case (address)
        PIO_DATA:    data_d = writedata[OUT_WIDTH-1:0];
        PIO_IRQMASK: mask_d = writedata[IN_WIDTH-1:0];
        PIO_EDGECAP: w1c    = writedata[IN_WIDTH-1:0];
        PIO_OUTSET:  data_d = data_q | writedata[OUT_WIDTH-1:0];
        PIO_OUTCLR:  data_d = data_q & ~writedata[OUT_WIDTH-1:0];
        default:     ;
      endcase
    end
    // A fresh edge overrides a same-cycle clear so no event is lost.
    cap_d = (cap_q & ~w1c) | edge_pulse;
  end

  // NOTE: reset is synchronous and covers every register, including the
  // capture bits, so a mid-run reset returns the block to a known state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q <= RESET_VALUE;
      mask_q <= '0;
      cap_q  <= '0;
    end else begin
      data_q <= data_d;
      mask_q <= mask_d;
      cap_q  <= cap_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      PIO_DATA:    readdata = 32'(data_q);
      PIO_INPUT:   readdata = 32'(in_sync);
      PIO_IRQMASK: readdata = 32'(mask_q);
      PIO_EDGECAP: readdata = 32'(cap_q);
      default:     ;
    endcase
  end

  assign out_port = data_q;
  assign irq      = |(cap_q & mask_q);

endmodule
